// File: rtl/cmp_peak_tracker_if.sv
// Sample stream interface for cmp_peak_tracker: producer drives valid/data, consumer drives ready.
// A sample transfers on a rising clock edge where in_valid and in_ready are both high; the producer
// keeps in_valid and in_data stable until that happens.
interface cmp_peak_tracker_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/cmp_peak_tracker.sv
// Running max/min tracker with previous-sample compare flags and a saturating sample counter.
// Define CMP_EVENT_CNT_EN to add saturating greater/lesser/equal event counters.
module cmp_peak_tracker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             hold,
  cmp_peak_tracker_if.slave s,
  output logic [WIDTH-1:0] max_out,
  output logic [WIDTH-1:0] min_out,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             cnt_sat,
  output logic             equal,
  output logic             greater,
  output logic             lesser,
  output logic             new_max,
  output logic             new_min,
`ifdef CMP_EVENT_CNT_EN
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
`endif
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_TRACK = 2'd1,
    ST_SAT   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] max_q, max_d, min_q, min_d, prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
  logic             nmax_q, nmax_d, nmin_q, nmin_d;
`ifdef CMP_EVENT_CNT_EN
  logic [CNT_W-1:0] gtc_q, gtc_d, ltc_q, ltc_d, eqc_q, eqc_d;
`endif

  logic accept;

  // clear blocks acceptance so a sample offered alongside it is never consumed
  assign s.in_ready = ~hold & ~clear;
  assign accept     = s.in_valid & s.in_ready;

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    min_d   = min_q;
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    nmax_d  = 1'b0;
    nmin_d  = 1'b0;
`ifdef CMP_EVENT_CNT_EN
    gtc_d   = gtc_q;
    ltc_d   = ltc_q;
    eqc_d   = eqc_q;
`endif
    if (clear) begin
      state_d = ST_EMPTY;
      max_d   = '0;
      min_d   = '0;
      prev_d  = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
      eq_d    = 1'b0;
      gt_d    = 1'b0;
      lt_d    = 1'b0;
`ifdef CMP_EVENT_CNT_EN
      gtc_d   = '0;
      ltc_d   = '0;
      eqc_d   = '0;
`endif
    end else if (accept) begin
      if (state_q == ST_EMPTY) begin
        // first sample has no predecessor: seeds max/min/prev, raises no compare flag
        max_d   = s.in_data;
        min_d   = s.in_data;
        prev_d  = s.in_data;
        cnt_d   = CNT_W'(1);
        sat_d   = &cnt_d;
        nmax_d  = 1'b1;
        nmin_d  = 1'b1;
        eq_d    = 1'b0;
        gt_d    = 1'b0;
        lt_d    = 1'b0;
        state_d = sat_d ? ST_SAT : ST_TRACK;
      end else begin
        eq_d   = (s.in_data == prev_q);
        gt_d   = (s.in_data >  prev_q);
        lt_d   = (s.in_data <  prev_q);
        prev_d = s.in_data;
        if (s.in_data > max_q) begin
          max_d  = s.in_data;
          nmax_d = 1'b1;
        end
        if (s.in_data < min_q) begin
          min_d  = s.in_data;
          nmin_d = 1'b1;
        end
        if (state_q == ST_TRACK) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (&cnt_d) begin
            sat_d   = 1'b1;
            state_d = ST_SAT;
          end
        end
`ifdef CMP_EVENT_CNT_EN
        if (gt_d && !(&gtc_q)) gtc_d = gtc_q + CNT_W'(1);
        if (lt_d && !(&ltc_q)) ltc_d = ltc_q + CNT_W'(1);
        if (eq_d && !(&eqc_q)) eqc_d = eqc_q + CNT_W'(1);
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      max_q   <= '0;
      min_q   <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      nmax_q  <= 1'b0;
      nmin_q  <= 1'b0;
`ifdef CMP_EVENT_CNT_EN
      gtc_q   <= '0;
      ltc_q   <= '0;
      eqc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      min_q   <= min_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      nmax_q  <= nmax_d;
      nmin_q  <= nmin_d;
`ifdef CMP_EVENT_CNT_EN
      gtc_q   <= gtc_d;
      ltc_q   <= ltc_d;
      eqc_q   <= eqc_d;
`endif
    end
  end

  assign max_out    = max_q;
  assign min_out    = min_q;
  assign sample_cnt = cnt_q;
  assign cnt_sat    = sat_q;
  assign equal      = eq_q;
  assign greater    = gt_q;
  assign lesser     = lt_q;
  assign new_max    = nmax_q;
  assign new_min    = nmin_q;
  assign dbg_state  = state_q;
`ifdef CMP_EVENT_CNT_EN
  assign gt_cnt     = gtc_q;
  assign lt_cnt     = ltc_q;
  assign eq_cnt     = eqc_q;
`endif

endmodule

// File: tb/tb_cmp_peak_tracker.sv
// Directed-vector bench for cmp_peak_tracker; observed outputs are packed as
// {max, min, new_max, new_min, equal, greater, lesser, sample_cnt, cnt_sat}.
module tb_cmp_peak_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic hold = 1'b0;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  cmp_peak_tracker_if #(.WIDTH(4)) bus ();

  logic [3:0] max_out, min_out;
  logic [7:0] sample_cnt;
  logic       cnt_sat, equal, greater, lesser, new_max, new_min;
  logic [1:0] dbg_state;
`ifdef CMP_EVENT_CNT_EN
  logic [7:0] gt_cnt, lt_cnt, eq_cnt;
`endif

  cmp_peak_tracker #(.WIDTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .hold       (hold),
    .s          (bus),
    .max_out    (max_out),
    .min_out    (min_out),
    .sample_cnt (sample_cnt),
    .cnt_sat    (cnt_sat),
    .equal      (equal),
    .greater    (greater),
    .lesser     (lesser),
    .new_max    (new_max),
    .new_min    (new_min),
`ifdef CMP_EVENT_CNT_EN
    .gt_cnt     (gt_cnt),
    .lt_cnt     (lt_cnt),
    .eq_cnt     (eq_cnt),
`endif
    .dbg_state  (dbg_state)
  );

  wire [21:0] obs = {max_out, min_out, new_max, new_min, equal, greater, lesser, sample_cnt, cnt_sat};

  always #5 clk = ~clk;

  task automatic send(input logic [3:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++;
    if (obs !== 22'h0) begin err_cnt++; $display("FAIL reset_outputs: got %h expected %h", obs, 22'h0); end
    vec_cnt++;
    if (dbg_state !== 2'd0) begin err_cnt++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    vec_cnt++;
    if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_ready: got %b expected 1", bus.in_ready); end
    hold = 1'b1; #1;
    vec_cnt++;
    if (bus.in_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_ready_hold: got %b expected 0", bus.in_ready); end
    hold = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    send(4'h5);
    vec_cnt++;
    if (obs !== {4'h5, 4'h5, 1'b1, 1'b1, 3'b000, 8'd1, 1'b0}) begin err_cnt++; $display("FAIL stream_a1: got %h", obs); end
    send(4'h9);
    vec_cnt++;
    if (obs !== {4'h9, 4'h5, 1'b1, 1'b0, 3'b010, 8'd2, 1'b0}) begin err_cnt++; $display("FAIL stream_a2: got %h", obs); end
    send(4'h2);
    vec_cnt++;
    if (obs !== {4'h9, 4'h2, 1'b0, 1'b1, 3'b001, 8'd3, 1'b0}) begin err_cnt++; $display("FAIL stream_a3: got %h", obs); end
    send(4'h9);
    vec_cnt++;
    if (obs !== {4'h9, 4'h2, 1'b0, 1'b0, 3'b010, 8'd4, 1'b0}) begin err_cnt++; $display("FAIL stream_a4: got %h", obs); end
    send(4'h2);
    vec_cnt++;
    if (obs !== {4'h9, 4'h2, 1'b0, 1'b0, 3'b001, 8'd5, 1'b0}) begin err_cnt++; $display("FAIL stream_a5: got %h", obs); end
    vec_cnt++;
    if (dbg_state !== 2'd1) begin err_cnt++; $display("FAIL stream_state: got %0d expected 1", dbg_state); end
  endtask

  task automatic test_hold();
    hold = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hF;
    #1;
    vec_cnt++;
    if (bus.in_ready !== 1'b0) begin err_cnt++; $display("FAIL hold_ready: got %b expected 0", bus.in_ready); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vec_cnt++;
      if (obs !== {4'h9, 4'h2, 1'b0, 1'b0, 3'b001, 8'd5, 1'b0}) begin err_cnt++; $display("FAIL hold_frozen%0d: got %h", i, obs); end
    end
    hold = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    vec_cnt++;
    if (obs !== {4'hF, 4'h2, 1'b1, 1'b0, 3'b010, 8'd6, 1'b0}) begin err_cnt++; $display("FAIL hold_release: got %h", obs); end
    @(posedge clk); #1;
    vec_cnt++;
    if (obs !== {4'hF, 4'h2, 1'b0, 1'b0, 3'b010, 8'd6, 1'b0}) begin err_cnt++; $display("FAIL hold_pulse_end: got %h", obs); end
  endtask

  task automatic test_equal();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    vec_cnt++;
    if (obs !== 22'h0) begin err_cnt++; $display("FAIL eq_clear: got %h expected 0", obs); end
    send(4'h7);
    vec_cnt++;
    if (obs !== {4'h7, 4'h7, 1'b1, 1'b1, 3'b000, 8'd1, 1'b0}) begin err_cnt++; $display("FAIL eq_first: got %h", obs); end
    send(4'h7);
    vec_cnt++;
    if (obs !== {4'h7, 4'h7, 1'b0, 1'b0, 3'b100, 8'd2, 1'b0}) begin err_cnt++; $display("FAIL eq_second: got %h", obs); end
  endtask

  task automatic test_clear_priority();
    clear = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h3;
    #1;
    vec_cnt++;
    if (bus.in_ready !== 1'b0) begin err_cnt++; $display("FAIL clr_ready: got %b expected 0", bus.in_ready); end
    @(posedge clk); #1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    vec_cnt++;
    if (obs !== 22'h0) begin err_cnt++; $display("FAIL clr_outputs: got %h expected 0", obs); end
    vec_cnt++;
    if (dbg_state !== 2'd0) begin err_cnt++; $display("FAIL clr_state: got %0d expected 0", dbg_state); end
    send(4'h3);
    vec_cnt++;
    if (obs !== {4'h3, 4'h3, 1'b1, 1'b1, 3'b000, 8'd1, 1'b0}) begin err_cnt++; $display("FAIL clr_then_3: got %h", obs); end
  endtask

  task automatic test_saturation();
    logic [21:0] e;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      send((k % 2 == 1) ? 4'h0 : 4'hF);
      e = {(k == 1) ? 4'h0 : 4'hF, 4'h0,
           (k <= 2) ? 1'b1 : 1'b0, (k == 1) ? 1'b1 : 1'b0,
           (k == 1) ? 3'b000 : ((k % 2 == 0) ? 3'b010 : 3'b001),
           (k > 255) ? 8'd255 : 8'(k),
           (k >= 255) ? 1'b1 : 1'b0};
      vec_cnt++;
      if (obs !== e) begin err_cnt++; $display("FAIL sat_accept%0d: got %h expected %h", k, obs, e); end
    end
    vec_cnt++;
    if (dbg_state !== 2'd2) begin err_cnt++; $display("FAIL sat_state: got %0d expected 2", dbg_state); end
`ifdef CMP_EVENT_CNT_EN
    vec_cnt++;
    if ({gt_cnt, lt_cnt, eq_cnt} !== {8'd150, 8'd149, 8'd0}) begin
      err_cnt++; $display("FAIL sat_evcnt: got %0d/%0d/%0d expected 150/149/0", gt_cnt, lt_cnt, eq_cnt);
    end
`endif
  endtask

  task automatic test_async_reset();
    send(4'h4);
    send(4'h6);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h9;
    #3;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    vec_cnt++;
    if (obs !== 22'h0) begin err_cnt++; $display("FAIL arst_outputs: got %h expected 0", obs); end
    vec_cnt++;
    if (dbg_state !== 2'd0) begin err_cnt++; $display("FAIL arst_state: got %0d expected 0", dbg_state); end
`ifdef CMP_EVENT_CNT_EN
    vec_cnt++;
    if ({gt_cnt, lt_cnt, eq_cnt} !== 24'h0) begin err_cnt++; $display("FAIL arst_evcnt: got %h expected 0", {gt_cnt, lt_cnt, eq_cnt}); end
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    vec_cnt++;
    if (obs !== 22'h0) begin err_cnt++; $display("FAIL arst_discard: got %h expected 0", obs); end
    send(4'h1);
    send(4'h2);
    send(4'h2);
    send(4'h1);
    vec_cnt++;
    if (obs !== {4'h2, 4'h1, 1'b0, 1'b0, 3'b001, 8'd4, 1'b0}) begin err_cnt++; $display("FAIL arst_stream: got %h", obs); end
`ifdef CMP_EVENT_CNT_EN
    vec_cnt++;
    if ({gt_cnt, lt_cnt, eq_cnt} !== {8'd1, 8'd1, 8'd1}) begin
      err_cnt++; $display("FAIL arst_evcnt_stream: got %0d/%0d/%0d expected 1/1/1", gt_cnt, lt_cnt, eq_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hold();
    test_equal();
    test_clear_priority();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
